// File: rtl/calc_operand_loader.sv
// Operand-entry front end: synchronizes and debounces ENTER, then captures two
// successive SW values as operands A and B for the downstream adder.
module calc_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIDTH           = 4
) (
  input  logic             CLOCK_50,
  input  logic [1:0]       KEY,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             operands_valid,
  output logic             pair_strobe,
  output logic [1:0]       state_led
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } state_e;

  logic             rst_n;
  logic [1:0]       sync_q;
  logic             btn_sync;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             valid_q, strobe_q;

  assign rst_n    = KEY[1];
  assign btn_sync = sync_q[1];

  // Everything resets to "pressed" so a button held through reset is ignored.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], ~KEY[0]};
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (btn_sync != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = btn_sync;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  // Only the debounced rising edge counts; release produces nothing.
  assign press = db_q & ~db_dly_q;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q  <= WAIT_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        WAIT_A: if (press) begin
          op_a_q  <= SW;
          state_q <= WAIT_B;
        end
        WAIT_B: if (press) begin
          op_b_q   <= SW;
          valid_q  <= 1'b1;
          strobe_q <= 1'b1;
          state_q  <= READY;
        end
        READY: if (press) begin
          op_a_q  <= SW;
          op_b_q  <= '0;
          valid_q <= 1'b0;
          state_q <= WAIT_B;
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign operands_valid = valid_q;
  assign pair_strobe    = strobe_q;
  assign state_led      = state_q;

endmodule

// File: tb/tb_calc_operand_loader.sv
// Scoreboard bench for calc_operand_loader with DEBOUNCE_CYCLES = 4: the
// stimulus queues expected output snapshots keyed by cycle, a monitor checks them.
module tb_calc_operand_loader;
  localparam int N = 4;
  localparam int W = 4;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic       s;
  } exp_t;

  logic         clk = 1'b0;
  logic [1:0]   KEY;
  logic [W-1:0] SW;
  logic [W-1:0] op_a, op_b;
  logic         operands_valid, pair_strobe;
  logic [1:0]   state_led;

  calc_operand_loader #(.DEBOUNCE_CYCLES(N), .WIDTH(W)) dut (
    .CLOCK_50(clk), .KEY(KEY), .SW(SW), .op_a(op_a), .op_b(op_b),
    .operands_valid(operands_valid), .pair_strobe(pair_strobe), .state_led(state_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [1:0] m_st;
  logic [3:0] m_a, m_b;
  logic       m_v, m_s;

  task automatic expect_at(input int c, input string nm);
    exp_t e;
    e.cyc = c; e.name = nm; e.st = m_st; e.a = m_a; e.b = m_b; e.v = m_v; e.s = m_s;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_st = 2'b00; m_a = 4'h0; m_b = 4'h0; m_v = 1'b0; m_s = 1'b0;
  endtask

  // Capture happens at edge e0+N+3 where e0 is the edge before KEY[0] falls.
  task automatic model_press(input int e0, input logic [3:0] sw, input string nm);
    case (m_st)
      2'b00: begin m_a = sw; m_st = 2'b01; expect_at(e0 + N + 3, nm); end
      2'b01: begin
        m_b = sw; m_v = 1'b1; m_s = 1'b1; m_st = 2'b10;
        expect_at(e0 + N + 3, nm);
        m_s = 1'b0;
        expect_at(e0 + N + 4, {nm, "_strobe_end"});
      end
      default: begin
        m_a = sw; m_b = 4'h0; m_v = 1'b0; m_st = 2'b01;
        expect_at(e0 + N + 3, nm);
      end
    endcase
  endtask

  task automatic press(input logic [3:0] sw, input int hold, input bit vary, input string nm);
    int e0;
    @(posedge clk); #1;
    e0 = cyc;
    SW = vary ? 4'h0 : sw;
    KEY[0] = 1'b0;
    model_press(e0, sw, nm);
    repeat (hold) begin
      @(posedge clk); #1;
      if (vary) SW = (cyc - e0 == N + 2) ? sw : 4'(cyc - e0);
    end
    KEY[0] = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    int e0;
    KEY = 2'b00; SW = 4'h0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    expect_at(cyc, "reset_state");
    KEY[1] = 1'b1;
    repeat (20) @(posedge clk); #1;
    expect_at(cyc, "held_through_reset");
    KEY[0] = 1'b1;
    repeat (12) @(posedge clk);

    press(4'h5, 10, 1'b0, "enter_a5");
    press(4'h3, 10, 1'b0, "enter_b3");
    press(4'hF, 10, 1'b0, "restart_aF");

    // Reset lands on the edge where the debounced press would be consumed.
    @(posedge clk); #1;
    e0 = cyc;
    SW = 4'h6; KEY[0] = 1'b0;
    repeat (N + 2) @(posedge clk); #1;
    KEY[1] = 1'b0;
    model_reset();
    expect_at(e0 + N + 3, "reset_mid_op");
    @(posedge clk); #1;
    KEY[1] = 1'b1;
    repeat (4) @(posedge clk); #1;
    KEY[0] = 1'b1;
    repeat (12) @(posedge clk);

    @(posedge clk); #1;
    SW = 4'h9;
    repeat (4) begin
      KEY[0] = 1'b0;
      repeat (3) @(posedge clk); #1;
      KEY[0] = 1'b1;
      @(posedge clk); #1;
    end
    repeat (12) @(posedge clk); #1;
    expect_at(cyc, "bounce_rejected");

    press(4'hA, 10, 1'b0, "clean_aA");
    press(4'hF, 10, 1'b0, "pair_AF");
    press(4'hF, 10, 1'b0, "restart_aF2");
    press(4'hF, 10, 1'b1, "vary_sw_bF");
    repeat (5) @(posedge clk);
    done = 1'b1;
  end

  logic [11:0] prev, cur;
  always @(negedge clk) begin
    exp_t e;
    cur = {state_led, op_a, op_b, operands_valid, pair_strobe};
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL pending_expectations got %0d left required 0 (next %s @%0d)",
                 q.size(), q[0].name, q[0].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (cyc >= 2) begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || cur !== {e.st, e.a, e.b, e.v, e.s}) begin
          failures++;
          $display("FAIL %s cyc=%0d got st=%b a=%h b=%h v=%b s=%b required st=%b a=%h b=%h v=%b s=%b",
                   e.name, cyc, state_led, op_a, op_b, operands_valid, pair_strobe,
                   e.st, e.a, e.b, e.v, e.s);
        end
      end else if (cur !== prev) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change cyc=%0d got st=%b a=%h b=%h v=%b s=%b required no change from %h",
                 cyc, state_led, op_a, op_b, operands_valid, pair_strobe, prev);
      end
    end
    prev = cur;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_operand_loader.md
# calc_operand_loader

Operand-entry front end for the four-bit calculator adder. It synchronizes and debounces the ENTER push-button, then captures two successive SW values as operands A and B. It presents both as stable registered words with a valid level and a one-cycle strobe for the downstream adder. It replaces direct KEY-clocked operand flip-flops with a single-clock, glitch-free sequencer.

## Interface
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a button level change. At 50 MHz this is 10 ms. Legal range is ≥ 2.
- WIDTH, default 4: operand width in bits.

- CLOCK_50  input  1  sole clock, rising edge.
- KEY  input  2
  - KEY[1] is the reset: synchronous, active-low, sampled on the CLOCK_50 rising edge.
  - KEY[0] is ENTER: active-low, asynchronous, bouncing.
- SW  input  WIDTH  operand value, sampled only at an accepted press.
- op_a  output  WIDTH  registered operand A.
- op_b  output  WIDTH  registered operand B.
- operands_valid  output  1  high while op_a/op_b hold a complete pair.
- pair_strobe  output  1  one-cycle pulse on the edge where the pair becomes complete.
- state_led  output  2  current FSM state encoding, for the board LEDs.

## Operation
- Synchronizer: two flops on ~KEY[0]; btn_sync = 1 means pressed. Both flops reset to 1.
- Debouncer: holds btn_db (reset 1) and counter cnt (width $clog2(DEBOUNCE_CYCLES), reset 0).
  - If btn_sync == btn_db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_db <= btn_sync and cnt <= 0.
  - Else: cnt <= cnt+1.
- Press detect: press = btn_db & ~btn_db_d, where btn_db_d is btn_db delayed one cycle (reset 1). Only the 0→1 transition of btn_db counts. Release generates nothing.
- Because everything resets to "pressed", a button held through reset produces no press until it is released and pressed again.
- FSM, state_led encoding: WAIT_A = 2'b00, WAIT_B = 2'b01, READY = 2'b10. 2'b11 is illegal and recovers to WAIT_A on the next edge.
  - WAIT_A, on press: op_a <= SW; go to WAIT_B.
  - WAIT_B, on press: op_b <= SW; operands_valid <= 1; pair_strobe <= 1; go to READY.
  - READY, on press: op_a <= SW; op_b <= 0; operands_valid <= 0; go to WAIT_B. This starts a new operation.
  - With no press, the state and all operand registers hold.
- pair_strobe is 0 in every cycle except the one after the WAIT_B→READY edge.
- Reset (KEY[1] low at an edge) sets on that edge:
  - op_a = 0, op_b = 0, operands_valid = 0, pair_strobe = 0, state = WAIT_A;
  - sync flops, btn_db and btn_db_d = 1; cnt = 0.
- Reset wins over a coincident press.
- Reset mid-debounce discards the partial count.
- Operands are unsigned WIDTH-bit values. No arithmetic is done here; carry/overflow belongs to the adder.

## Timing
- Latency from a clean KEY[0] fall to a register update, with N = DEBOUNCE_CYCLES and edge 1 = the first edge sampling KEY[0] low:
  - btn_sync = 1 after edge 2;
  - btn_db = 1 after edge N+2;
  - press is high during the following cycle;
  - op_a / op_b / state update at edge N+3.
- SW is sampled at edge N+3 only. SW changes while the button is held have no effect.
- operands_valid and pair_strobe rise at the same edge as op_b updates. pair_strobe falls one edge later.
- Any bounce shorter than N consecutive cycles at the synchronized level produces no press.
- One press yields exactly one FSM transition, regardless of hold length.
- After reset with the button released, btn_db returns to 0 at edge N+2 after reset deasserts. A press is accepted only after that.

## Test plan
Use DEBOUNCE_CYCLES = 4 throughout.
- Reset: hold KEY[1]=0 for 3 cycles with KEY[0]=0 (held) → op_a=0, op_b=0, operands_valid=0, pair_strobe=0, state_led=00. Release KEY[1] while KEY[0] stays held for 20 cycles → no state change.
- Entry sequence: SW=5, press (KEY[0] low 10 cycles) → op_a=5 at edge 7, state_led=01. Then SW=3, press → op_b=3, operands_valid=1, state_led=10, pair_strobe high for exactly one cycle.
- Bounce rejection: in WAIT_A, toggle KEY[0] low 3 cycles / high 1 cycle ×4, then high → op_a unchanged, state_led=00. Then a clean press with SW=A → op_a=A.
- Restart from READY: after the pair (5,3), set SW=F and press → op_a=F, op_b=0, operands_valid=0, state_led=01, no pair_strobe.
- Reset mid-operation: in WAIT_B, assert KEY[1] low at the edge where press is high → state_led=00, op_a=0, no op_b capture, no pair_strobe.
- Full-range values: enter A=F, B=F → op_a=F, op_b=F, operands_valid=1. Hold SW changing every cycle during a held press → only the value at edge N+3 is captured.
